avalon_lsu_host: RTL and testbench

Avalon-MM host that turns single load/store requests from the core into bus transactions on an `AvalonMmRw.Host` port. It drives memory and peripheral agents on the data side. It computes the word-aligned address and byte lanes, shifts store data into the correct lanes, and honours `waitrequest` and `readdatavalid`. Load data is extracted and sign- or zero-extended before being returned to the core. It handles one transaction at a time and sits between the core's execute/memory stage and the data bus.

---
 rtl/avalon_lsu_host_if.sv | 21 ++
 rtl/avalon_lsu_host.sv | 205 ++++++++++++++++++++
 tb/tb_avalon_lsu_host.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_lsu_host_if.sv
// Avalon-MM read/write port shared by the load/store host and its agents.
interface AvalonMmRw;
   logic [31:0] address;
   logic [3:0]  byteenable;
   logic        read;
   logic        write;
   logic [31:0] host_to_agent;
   logic [31:0] agent_to_host;
   logic        waitrequest;
   logic        readdatavalid;

   modport Host (
      output address, byteenable, read, write, host_to_agent,
      input  agent_to_host, waitrequest, readdatavalid
   );

   modport Agent (
      input  address, byteenable, read, write, host_to_agent,
      output agent_to_host, waitrequest, readdatavalid
   );
endinterface

// File: rtl/avalon_lsu_host.sv
// Avalon-MM load/store host: one core request at a time becomes one bus
// transaction; store data is lane-shifted, load data is lane-selected and
// sign/zero-extended. Misaligned or illegal-size requests never reach the bus.
module avalon_lsu_host #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   AvalonMmRw.Host     bus
);

   // The counter holds completed WAIT cycles; the timeout fires on the edge
   // that completes the TIMEOUT-th one, i.e. when it equals TIMEOUT-1.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

   state_t      state, state_next;

   // Latched request attributes needed after the bus command is issued.
   logic        is_write_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [1:0]  lane_q;

   // Registered bus command fields.
   logic [31:0] cmd_address;
   logic [3:0]  cmd_byteenable;
   logic        cmd_read;
   logic        cmd_write;
   logic [31:0] cmd_wdata;

   logic [CW-1:0] tmo_cnt;

   logic        illegal;
   logic [3:0]  size_mask;
   logic        accept_ok, accept_err, cmd_done, load_done, load_timeout;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign req_ready          = (state == IDLE);
   assign bus.address        = cmd_address;
   assign bus.byteenable     = cmd_byteenable;
   assign bus.read           = cmd_read;
   assign bus.write          = cmd_write;
   assign bus.host_to_agent  = cmd_wdata;

   // Request legality and byte-lane mask for the incoming request.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch is never inferred.
      size_mask = 4'b1111;
      illegal   = 1'b0;
      case (req_size)
         2'd0: size_mask = 4'b0001;
         2'd1: begin
            size_mask = 4'b0011;
            illegal   = req_addr[0];
         end
         2'd2: illegal = (req_addr[1:0] != 2'b00);
         default: illegal = 1'b1;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic and single-cycle control strobes.
   always_comb begin
      state_next   = state;
      accept_ok    = 1'b0;
      accept_err   = 1'b0;
      cmd_done     = 1'b0;
      load_done    = 1'b0;
      load_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (illegal) begin
                  accept_err = 1'b1;
               end else begin
                  accept_ok  = 1'b1;
                  state_next = CMD;
               end
            end
         end
         CMD: begin
            if (!bus.waitrequest) begin
               cmd_done   = 1'b1;
               state_next = is_write_q ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (bus.readdatavalid) begin
               load_done  = 1'b1;
               state_next = IDLE;
            end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
               load_timeout = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Lane selection and extension of returned load data.
   always_comb begin
      byte_lane = bus.agent_to_host[7:0];
      case (lane_q)
         2'd1:    byte_lane = bus.agent_to_host[15:8];
         2'd2:    byte_lane = bus.agent_to_host[23:16];
         2'd3:    byte_lane = bus.agent_to_host[31:24];
         default: byte_lane = bus.agent_to_host[7:0];
      endcase
      half_lane = lane_q[1] ? bus.agent_to_host[31:16] : bus.agent_to_host[15:0];
      case (size_q)
         2'd0:    load_data = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
         2'd1:    load_data = {{16{~unsigned_q & half_lane[15]}}, half_lane};
         default: load_data = bus.agent_to_host;
      endcase
   end

   // Request capture, bus command registers, timeout counter and response.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         is_write_q     <= 1'b0;
         size_q         <= 2'd0;
         unsigned_q     <= 1'b0;
         lane_q         <= 2'd0;
         cmd_address    <= 32'h0;
         cmd_byteenable <= 4'h0;
         cmd_read       <= 1'b0;
         cmd_write      <= 1'b0;
         cmd_wdata      <= 32'h0;
         tmo_cnt        <= '0;
         rsp_valid      <= 1'b0;
         rsp_error      <= 1'b0;
         rsp_rdata      <= 32'h0;
      end else begin
         rsp_valid <= 1'b0;

         if (accept_ok) begin
            is_write_q     <= req_write;
            size_q         <= req_size;
            unsigned_q     <= req_unsigned;
            lane_q         <= req_addr[1:0];
            cmd_address    <= {req_addr[31:2], 2'b00};
            cmd_byteenable <= size_mask << req_addr[1:0];
            cmd_wdata      <= req_wdata << {req_addr[1:0], 3'b000};
            cmd_read       <= ~req_write;
            cmd_write      <= req_write;
         end

         if (accept_err) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'h0;
         end

         if (cmd_done) begin
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            tmo_cnt   <= '0;
            if (is_write_q) begin
               rsp_valid <= 1'b1;
               rsp_error <= 1'b0;
               rsp_rdata <= 32'h0;
            end
         end

         if ((state == WAIT) && !load_done && !load_timeout)
            tmo_cnt <= tmo_cnt + CW'(1);

         if (load_done) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= load_data;
         end

         if (load_timeout) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_avalon_lsu_host.sv
// Directed bench for avalon_lsu_host. Cycle n is the clock period after
// edge n-1, where edge 0 accepts the request; outputs are sampled 1 ns after
// each rising edge, before the next input change.
module tb_avalon_lsu_host;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   int vectors     = 0;
   int miscompares = 0;
   int read_cycles = 0;
   int reads_accepted = 0;
   int snap_cycles;
   int snap_accepted;

   AvalonMmRw bus ();

   avalon_lsu_host #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_error    (rsp_error),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Count bus cycles with read high and read commands the agent accepted.
   always @(posedge clk) begin
      if (bus.read === 1'b1) read_cycles++;
      if (bus.read === 1'b1 && bus.waitrequest === 1'b0) reads_accepted++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; returns in cycle 1.
   task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
      req_valid    = 1'b1;
      req_write    = w;
      req_addr     = a;
      req_size     = s;
      req_unsigned = u;
      req_wdata    = d;
      tick();
      req_valid    = 1'b0;
   endtask

   // Load against a one-cycle agent returning 'word' in cycle 2.
   task automatic load_1cycle(input string tag, input logic [31:0] a, input logic [1:0] s,
                              input logic u, input logic [31:0] word, input logic [31:0] exp);
      send(1'b0, a, s, u, 32'h0);
      check({tag, " c1 read"}, {31'h0, bus.read}, 32'h1);
      tick();
      bus.readdatavalid = 1'b1;
      bus.agent_to_host = word;
      check({tag, " c2 rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
      tick();
      bus.readdatavalid = 1'b0;
      bus.agent_to_host = 32'h0;
      check({tag, " c3 rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
      check({tag, " c3 rsp_error"}, {31'h0, rsp_error}, 32'h0);
      check({tag, " c3 rsp_rdata"}, rsp_rdata, exp);
      tick();
      check({tag, " c4 rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
   endtask

   initial begin
      reset_n           = 1'b0;
      req_valid         = 1'b0;
      req_write         = 1'b0;
      req_addr          = 32'h0;
      req_size          = 2'd0;
      req_unsigned      = 1'b0;
      req_wdata         = 32'h0;
      bus.agent_to_host = 32'h0;
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;

      // Reset values
      tick();
      tick();
      check("rst read",       {31'h0, bus.read},  32'h0);
      check("rst write",      {31'h0, bus.write}, 32'h0);
      check("rst byteenable", {28'h0, bus.byteenable}, 32'h0);
      check("rst address",    bus.address, 32'h0);
      check("rst h2a",        bus.host_to_agent, 32'h0);
      check("rst rsp_valid",  {31'h0, rsp_valid}, 32'h0);
      check("rst rsp_error",  {31'h0, rsp_error}, 32'h0);
      check("rst rsp_rdata",  rsp_rdata, 32'h0);
      reset_n = 1'b1;
      tick();
      check("post-rst req_ready", {31'h0, req_ready}, 32'h1);

      // Word store 0xDEADBEEF at 0x10
      send(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
      check("wst c1 write",      {31'h0, bus.write}, 32'h1);
      check("wst c1 read",       {31'h0, bus.read},  32'h0);
      check("wst c1 address",    bus.address, 32'h10);
      check("wst c1 byteenable", {28'h0, bus.byteenable}, 32'hF);
      check("wst c1 h2a",        bus.host_to_agent, 32'hDEADBEEF);
      check("wst c1 req_ready",  {31'h0, req_ready}, 32'h0);
      check("wst c1 rsp_valid",  {31'h0, rsp_valid}, 32'h0);
      tick();
      check("wst c2 rsp_valid",  {31'h0, rsp_valid}, 32'h1);
      check("wst c2 rsp_error",  {31'h0, rsp_error}, 32'h0);
      check("wst c2 write",      {31'h0, bus.write}, 32'h0);
      check("wst c2 req_ready",  {31'h0, req_ready}, 32'h1);
      tick();
      check("wst c3 rsp_valid",  {31'h0, rsp_valid}, 32'h0);

      // Sub-word and word loads from agent word 0x80FF7F01
      load_1cycle("lb 0x12",  32'h12, 2'd0, 1'b0, 32'h80FF7F01, 32'hFFFFFFFF);
      load_1cycle("lbu 0x12", 32'h12, 2'd0, 1'b1, 32'h80FF7F01, 32'h000000FF);
      load_1cycle("lb 0x11",  32'h11, 2'd0, 1'b0, 32'h80FF7F01, 32'h0000007F);
      load_1cycle("lh 0x12",  32'h12, 2'd1, 1'b0, 32'h80FF7F01, 32'hFFFF80FF);
      load_1cycle("lhu 0x10", 32'h10, 2'd1, 1'b1, 32'h80FF7F01, 32'h00007F01);
      load_1cycle("lw 0x10",  32'h10, 2'd2, 1'b0, 32'h80FF7F01, 32'h80FF7F01);

      // Byte store to the upper lane; store response carries zero data
      send(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000AB);
      check("sb c1 byteenable", {28'h0, bus.byteenable}, 32'h8);
      check("sb c1 h2a",        bus.host_to_agent, 32'hAB000000);
      check("sb c1 address",    bus.address, 32'h10);
      tick();
      check("sb c2 rsp_valid",  {31'h0, rsp_valid}, 32'h1);
      check("sb c2 rsp_rdata",  rsp_rdata, 32'h0);
      tick();

      // Stall: waitrequest high for cycles 1..3 of a word load at 0x24
      snap_accepted   = reads_accepted;
      bus.waitrequest = 1'b1;
      send(1'b0, 32'h24, 2'd2, 1'b0, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) bus.waitrequest = 1'b0;
         check($sformatf("stall c%0d read", c),       {31'h0, bus.read}, 32'h1);
         check($sformatf("stall c%0d address", c),    bus.address, 32'h24);
         check($sformatf("stall c%0d byteenable", c), {28'h0, bus.byteenable}, 32'hF);
         check($sformatf("stall c%0d rsp_valid", c),  {31'h0, rsp_valid}, 32'h0);
         tick();
      end
      // Now in cycle 5
      check("stall c5 read", {31'h0, bus.read}, 32'h0);
      bus.readdatavalid = 1'b1;
      bus.agent_to_host = 32'h12345678;
      tick();
      bus.readdatavalid = 1'b0;
      check("stall c6 rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall c6 rsp_rdata", rsp_rdata, 32'h12345678);
      check("stall reads accepted", reads_accepted - snap_accepted, 32'd1);
      tick();

      // Misaligned word load at 0x11: error in cycle 1, no bus cycle
      snap_cycles = read_cycles;
      send(1'b0, 32'h11, 2'd2, 1'b0, 32'h0);
      check("mis c1 rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("mis c1 rsp_error", {31'h0, rsp_error}, 32'h1);
      check("mis c1 rsp_rdata", rsp_rdata, 32'h0);
      check("mis c1 read",      {31'h0, bus.read}, 32'h0);
      check("mis c1 req_ready", {31'h0, req_ready}, 32'h1);
      tick();
      check("mis c2 rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("mis read cycles",  read_cycles - snap_cycles, 32'd0);

      // Illegal size 3 and misaligned half: errors, no bus cycle
      send(1'b1, 32'h20, 2'd3, 1'b0, 32'h0);
      check("sz3 c1 rsp_error", {31'h0, rsp_error}, 32'h1);
      check("sz3 c1 write",     {31'h0, bus.write}, 32'h0);
      tick();
      send(1'b0, 32'h13, 2'd1, 1'b0, 32'h0);
      check("mish c1 rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("mish c1 rsp_error", {31'h0, rsp_error}, 32'h1);
      tick();
      check("err read cycles", read_cycles - snap_cycles, 32'd0);

      // Good load to leave non-zero rsp_rdata before the timeout case
      load_1cycle("lw 0x30", 32'h30, 2'd2, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);

      // Timeout (TIMEOUT=4): no readdatavalid, error in cycle 6
      send(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("tmo c%0d rsp_valid", c), {31'h0, rsp_valid}, 32'h0);
         tick();
      end
      check("tmo c6 rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("tmo c6 rsp_error", {31'h0, rsp_error}, 32'h1);
      check("tmo c6 rsp_rdata", rsp_rdata, 32'h0);
      check("tmo c6 req_ready", {31'h0, req_ready}, 32'h1);

      // Late readdatavalid outside WAIT is ignored
      bus.readdatavalid = 1'b1;
      bus.agent_to_host = 32'h55AA55AA;
      tick();
      bus.readdatavalid = 1'b0;
      check("late c7 rsp_valid", {31'h0, rsp_valid}, 32'h0);
      tick();
      check("late c8 rsp_valid", {31'h0, rsp_valid}, 32'h0);

      // Reset while in WAIT, then a late readdatavalid
      send(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
      tick();
      check("rstw c2 read", {31'h0, bus.read}, 32'h0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("rstw read",       {31'h0, bus.read},  32'h0);
      check("rstw write",      {31'h0, bus.write}, 32'h0);
      check("rstw byteenable", {28'h0, bus.byteenable}, 32'h0);
      check("rstw address",    bus.address, 32'h0);
      check("rstw h2a",        bus.host_to_agent, 32'h0);
      check("rstw rsp_valid",  {31'h0, rsp_valid}, 32'h0);
      check("rstw rsp_error",  {31'h0, rsp_error}, 32'h0);
      check("rstw rsp_rdata",  rsp_rdata, 32'h0);
      bus.readdatavalid = 1'b1;
      bus.agent_to_host = 32'h0BADF00D;
      tick();
      bus.readdatavalid = 1'b0;
      check("rstw late rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rstw late req_ready", {31'h0, req_ready}, 32'h1);
      tick();
      check("rstw end rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rstw end rsp_rdata", rsp_rdata, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
